// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between instruction fetch and data access.
// Optional anti-starvation guard for fetch enabled by defining ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_valid,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_valid,
    output logic                m_en,
    output logic                m_we,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    input  logic [DATA_W-1:0]   m_rdata,
    output logic                stall_if,
    output logic                stall_mem
);

    localparam int STRB_W = DATA_W / 8;
    localparam int LAT_W  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_owner_d;
    logic [LAT_W-1:0]    r_lat_cnt;
    logic                r_if_kill;
    logic                r_m_en;
    logic                r_m_we;
    logic [ADDR_W-1:0]   r_m_addr;
    logic [DATA_W-1:0]   r_m_wdata;
    logic [STRB_W-1:0]   r_m_wstrb;

    logic                w_force_if;
    logic                w_grant_d;
    logic                w_grant_if;
    logic                w_done;

    always_comb begin
        w_grant_d  = 1'b0;
        w_grant_if = 1'b0;
        if (r_state == S_IDLE) begin
            w_grant_d  = d_req && !w_force_if;
            w_grant_if = if_req && !w_grant_d;
        end
    end

    // A store completes in its issue cycle; reads complete when the latency count expires.
    always_comb begin
        w_done = 1'b0;
        if (r_state == S_ACCESS && r_m_we)
            w_done = 1'b1;
        else if (r_state == S_WAIT && r_lat_cnt == '0)
            w_done = 1'b1;
    end

`ifdef ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [SW-1:0] r_starve;

    assign w_force_if = (r_starve == SW'(STARVE_MAX)) && d_req && if_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve <= '0;
        end else if (w_grant_if || (r_state == S_IDLE && !if_req)) begin
            r_starve <= '0;
        end else if (w_grant_d && if_req && r_starve != SW'(STARVE_MAX)) begin
            r_starve <= r_starve + 1'b1;
        end
    end
`else
    assign w_force_if = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_grant_d || w_grant_if)
                    w_next = S_ACCESS;
            end
            S_ACCESS: begin
                w_next = r_m_we ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                if (r_lat_cnt == '0)
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        if_valid = w_done && !r_owner_d && if_req && !r_if_kill;
        d_valid  = w_done && r_owner_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lat_cnt <= '0;
        end else if (r_state == S_ACCESS) begin
            r_lat_cnt <= LAT_W'(MEM_LAT - 1);
        end else if (r_state == S_WAIT && r_lat_cnt != '0) begin
            r_lat_cnt <= r_lat_cnt - 1'b1;
        end
    end

    // Memory port registers are loaded only on a grant so they stay stable through the access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_en    <= 1'b0;
            r_m_we    <= 1'b0;
            r_owner_d <= 1'b0;
            r_m_addr  <= '0;
            r_m_wdata <= '0;
            r_m_wstrb <= '0;
        end else begin
            r_m_en <= w_grant_d || w_grant_if;
            if (w_grant_d) begin
                r_owner_d <= 1'b1;
                r_m_we    <= d_we;
                r_m_addr  <= d_addr;
                r_m_wdata <= d_wdata;
                r_m_wstrb <= d_we ? d_wstrb : '0;
            end else if (w_grant_if) begin
                r_owner_d <= 1'b0;
                r_m_we    <= 1'b0;
                r_m_addr  <= if_addr;
                r_m_wdata <= '0;
                r_m_wstrb <= '0;
            end
        end
    end

    // Once a fetch is withdrawn its data is stale even if the request is raised again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_if_kill <= 1'b0;
        end else if (w_grant_d || w_grant_if) begin
            r_if_kill <= 1'b0;
        end else if (r_state != S_IDLE && !r_owner_d && !if_req) begin
            r_if_kill <= 1'b1;
        end
    end

    assign m_en      = r_m_en;
    assign m_we      = r_m_we;
    assign m_addr    = r_m_addr;
    assign m_wdata   = r_m_wdata;
    assign m_wstrb   = r_m_wstrb;
    assign if_rdata  = m_rdata;
    assign d_rdata   = m_rdata;
    assign stall_if  = if_req && !if_valid;
    assign stall_mem = d_req && !d_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard testbench for mem_port_arbiter with a behavioural single-port memory.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_wstrb = '0;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        m_en;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic [31:0] m_rdata;
    logic        stall_if;
    logic        stall_mem;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        is_d;
        logic        chk;
        logic [31:0] data;
    } exp_t;

    exp_t sbq[$];

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_rdata(d_rdata), .d_valid(d_valid),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_rdata(m_rdata), .stall_if(stall_if), .stall_mem(stall_mem)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] f_init(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // Single-port memory, read latency 1
    logic [31:0] mem [logic [31:0]];
    logic [31:0] r_rdata = '0;
    assign m_rdata = r_rdata;

    always @(posedge clk) begin
        logic [31:0] cur;
        if (m_en) begin
            cur = mem.exists(m_addr) ? mem[m_addr] : f_init(m_addr);
            if (m_we) begin
                for (int b = 0; b < 4; b++)
                    if (m_wstrb[b]) cur[8*b +: 8] = m_wdata[8*b +: 8];
                mem[m_addr] = cur;
            end else begin
                r_rdata <= cur;
            end
        end
    end

    // Scoreboard: every valid pulse pops one expectation
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] got;
        if (rst_n && (if_valid || d_valid)) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: if_valid=%0b d_valid=%0b, required none", if_valid, d_valid);
            end else begin
                e = sbq.pop_front();
                if (d_valid !== e.is_d) begin
                    errors++;
                    $display("FAIL sb_owner: d_valid=%0b if_valid=%0b, required data-owner=%0b", d_valid, if_valid, e.is_d);
                end
                if (e.chk) begin
                    checks++;
                    got = d_valid ? d_rdata : if_rdata;
                    if (got !== e.data) begin
                        errors++;
                        $display("FAIL sb_rdata: got %h, required %h", got, e.data);
                    end
                end
            end
        end
    end

    ap_dreq_held: assert property (@(posedge clk) disable iff (!rst_n)
        (d_req && !d_valid) |=> d_req)
        else $display("FAIL d_req_withdrawn: d_req dropped before d_valid");

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic test_reset();
        tick(); tick();
        smp();
        checks++;
        if ({m_en, m_we, if_valid, d_valid, stall_if, stall_mem} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: en/we/ifv/dv/sif/smem=%b, required 000000",
                     {m_en, m_we, if_valid, d_valid, stall_if, stall_mem});
        end
        checks++;
        if (m_addr !== 32'h0 || m_wdata !== 32'h0 || m_wstrb !== 4'h0) begin
            errors++;
            $display("FAIL reset_port: addr=%h wdata=%h wstrb=%h, required 0", m_addr, m_wdata, m_wstrb);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_if_read();
        tick();
        if_req = 1'b1; if_addr = 32'h100;
        sbq.push_back('{1'b0, 1'b1, 32'hDEADBEEF});
        smp();
        checks++;
        if (stall_if !== 1'b1 || m_en !== 1'b0) begin
            errors++;
            $display("FAIL ifrd_T: stall_if=%0b m_en=%0b, required 1 0", stall_if, m_en);
        end
        tick(); smp();
        checks++;
        if (m_en !== 1'b1 || m_we !== 1'b0 || m_addr !== 32'h100 || stall_if !== 1'b1) begin
            errors++;
            $display("FAIL ifrd_T1: en=%0b we=%0b addr=%h stall_if=%0b, required 1 0 100 1",
                     m_en, m_we, m_addr, stall_if);
        end
        tick(); smp();
        checks++;
        if (if_valid !== 1'b1 || if_rdata !== 32'hDEADBEEF || stall_if !== 1'b0) begin
            errors++;
            $display("FAIL ifrd_T2: if_valid=%0b rdata=%h stall_if=%0b, required 1 deadbeef 0",
                     if_valid, if_rdata, stall_if);
        end
        tick();
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_store();
        tick();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2004; d_wdata = 32'h12345678; d_wstrb = 4'h3;
        sbq.push_back('{1'b1, 1'b0, 32'h0});
        smp();
        checks++;
        if (stall_mem !== 1'b1) begin
            errors++;
            $display("FAIL st_stall: stall_mem=%0b, required 1", stall_mem);
        end
        tick(); smp();
        checks++;
        if (m_en !== 1'b1 || m_we !== 1'b1 || m_wstrb !== 4'h3 || m_addr !== 32'h2004 ||
            m_wdata !== 32'h12345678) begin
            errors++;
            $display("FAIL st_port: en=%0b we=%0b strb=%h addr=%h wdata=%h, required 1 1 3 2004 12345678",
                     m_en, m_we, m_wstrb, m_addr, m_wdata);
        end
        checks++;
        if (d_valid !== 1'b1 || stall_mem !== 1'b0) begin
            errors++;
            $display("FAIL st_valid: d_valid=%0b stall_mem=%0b, required 1 0", d_valid, stall_mem);
        end
        tick();
        d_req = 1'b0; d_we = 1'b0; d_wstrb = 4'h0;
        // Read back: only the two low bytes were replaced
        d_req = 1'b1; d_addr = 32'h2004;
        sbq.push_back('{1'b1, 1'b1, (f_init(32'h2004) & 32'hFFFF_0000) | 32'h0000_5678});
        tick(); smp();
        checks++;
        if (m_en !== 1'b1 || m_we !== 1'b0) begin
            errors++;
            $display("FAIL ld_port: en=%0b we=%0b, required 1 0", m_en, m_we);
        end
        tick(); smp();
        checks++;
        if (d_valid !== 1'b1) begin
            errors++;
            $display("FAIL ld_valid: d_valid=%0b, required 1", d_valid);
        end
        tick();
        d_req = 1'b0;
        tick();
    endtask

    task automatic test_contention();
        tick();
        if_req = 1'b1; if_addr = 32'h400;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h800;
        sbq.push_back('{1'b1, 1'b1, f_init(32'h800)});
        sbq.push_back('{1'b0, 1'b1, f_init(32'h400)});
        tick(); smp();
        checks++;
        if (m_en !== 1'b1 || m_addr !== 32'h800) begin
            errors++;
            $display("FAIL ct_first: en=%0b addr=%h, required 1 800", m_en, m_addr);
        end
        tick(); smp();
        checks++;
        if (d_valid !== 1'b1 || stall_if !== 1'b1) begin
            errors++;
            $display("FAIL ct_dvalid: d_valid=%0b stall_if=%0b, required 1 1", d_valid, stall_if);
        end
        tick();
        d_req = 1'b0;
        smp();
        checks++;
        if (m_en !== 1'b0) begin
            errors++;
            $display("FAIL ct_idle: m_en=%0b, required 0", m_en);
        end
        tick(); smp();
        checks++;
        if (m_en !== 1'b1 || m_addr !== 32'h400) begin
            errors++;
            $display("FAIL ct_second: en=%0b addr=%h, required 1 400", m_en, m_addr);
        end
        tick(); smp();
        checks++;
        if (if_valid !== 1'b1) begin
            errors++;
            $display("FAIL ct_ifvalid: if_valid=%0b, required 1", if_valid);
        end
        tick();
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_withdraw();
        tick();
        if_req = 1'b1; if_addr = 32'h500;
        tick();
        if_req = 1'b0;
        smp();
        checks++;
        if (m_en !== 1'b1 || m_addr !== 32'h500) begin
            errors++;
            $display("FAIL wd_access: en=%0b addr=%h, required 1 500", m_en, m_addr);
        end
        tick(); smp();
        checks++;
        if (if_valid !== 1'b0) begin
            errors++;
            $display("FAIL wd_suppress: if_valid=%0b, required 0", if_valid);
        end
        tick();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600;
        sbq.push_back('{1'b1, 1'b1, f_init(32'h600)});
        tick(); smp();
        checks++;
        if (m_en !== 1'b1 || m_addr !== 32'h600) begin
            errors++;
            $display("FAIL wd_regrant: en=%0b addr=%h, required 1 600", m_en, m_addr);
        end
        tick(); smp();
        checks++;
        if (d_valid !== 1'b1) begin
            errors++;
            $display("FAIL wd_dvalid: d_valid=%0b, required 1", d_valid);
        end
        tick();
        d_req = 1'b0;
        tick();
    endtask

    task automatic test_starve();
        int nd;
        int ifpos;
        int cyc;
        int exp_pos;
`ifdef ARB_STARVE_GUARD_EN
        exp_pos = 4;
`else
        exp_pos = 5;
`endif
        for (int k = 0; k < 6; k++) begin
            if (k == exp_pos)
                sbq.push_back('{1'b0, 1'b1, f_init(32'h700)});
            else if (k < exp_pos)
                sbq.push_back('{1'b1, 1'b1, f_init(32'h1000 + 32'(4 * k))});
            else
                sbq.push_back('{1'b1, 1'b1, f_init(32'h1000 + 32'(4 * (k - 1)))});
        end
        tick();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1000;
        if_req = 1'b1; if_addr = 32'h700;
        nd = 0; ifpos = -1; cyc = 0;
        while ((nd < 5 || ifpos < 0) && cyc < 200) begin
            smp();
            if (d_valid) nd++;
            if (if_valid) ifpos = nd;
            tick();
            cyc++;
            if (nd >= 5) d_req = 1'b0;
            else d_addr = 32'h1000 + 32'(4 * nd);
            if (ifpos >= 0) if_req = 1'b0;
        end
        d_req = 1'b0; if_req = 1'b0;
        checks++;
        if (cyc >= 200) begin
            errors++;
            $display("FAIL starve_timeout: loads=%0d if_pos=%0d after %0d cycles, required completion", nd, ifpos, cyc);
        end
        checks++;
        if (ifpos != exp_pos) begin
            errors++;
            $display("FAIL starve_order: IF served after %0d loads, required %0d", ifpos, exp_pos);
        end
        tick();
    endtask

    task automatic test_reset_wait();
        tick();
        if_req = 1'b1; if_addr = 32'h300;
        tick();
        tick();
        rst_n = 1'b0; if_req = 1'b0;
        smp();
        checks++;
        if ({m_en, m_we, if_valid, d_valid, stall_if, stall_mem} !== 6'b0 ||
            m_addr !== 32'h0 || m_wstrb !== 4'h0 || m_wdata !== 32'h0) begin
            errors++;
            $display("FAIL rstwait_outputs: ctrl=%b addr=%h, required 000000 0",
                     {m_en, m_we, if_valid, d_valid, stall_if, stall_mem}, m_addr);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            smp();
            checks++;
            if (m_en !== 1'b0 || if_valid !== 1'b0 || d_valid !== 1'b0) begin
                errors++;
                $display("FAIL rstwait_quiet%0d: en=%0b ifv=%0b dv=%0b, required 0 0 0",
                         i, m_en, if_valid, d_valid);
            end
            tick();
        end
    endtask

    initial begin
        mem[32'h100] = 32'hDEADBEEF;
        test_reset();
        test_if_read();
        test_store();
        test_contention();
        test_withdraw();
        test_starve();
        test_reset_wait();
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d expected results never seen, required 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences a single shared single-port synchronous memory between the instruction-fetch (IF) requester and the data (MEM-stage load/store) requester of the pipelined core. It arbitrates each access, drives the memory port for one issue cycle, waits out the fixed read latency, returns data with a one-cycle valid strobe, and generates per-stage stall signals for the pipeline controller. Data accesses have priority; an optional anti-starvation guard bounds IF wait time.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (byte strobe width = DATA_W/8)
- MEM_LAT, 1, cycles from memory enable to read data valid (>=1)
- STARVE_MAX, 4, consecutive data grants tolerated while IF waits (guard only)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; may be withdrawn (flush)
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetch data
- if_valid  out  1  fetch complete, one-cycle pulse
- d_req  in  1  data request; held until d_valid
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_wstrb  in  DATA_W/8  store byte enables
- d_rdata  out  DATA_W  load data
- d_valid  out  1  data access complete, one-cycle pulse
- m_en  out  1  memory enable, one-cycle pulse per access
- m_we  out  1  memory write enable
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_wstrb  out  DATA_W/8  memory byte enables
- m_rdata  in  DATA_W  memory read data
- stall_if  out  1  if_req && !if_valid
- stall_mem  out  1  d_req && !d_valid

## Operation
- FSM states IDLE, ACCESS, WAIT; owner register (IF/DATA); latency counter.
- IDLE: if d_req (and guard not forcing IF) grant DATA, else if if_req grant IF; latch owner, address, we, wdata, wstrb (IF: we=0, wstrb=0) into m_* registers; go ACCESS. No request: stay IDLE.
- ACCESS: m_en=1 for this cycle only. Write: assert d_valid this cycle, go IDLE. Read: load counter MEM_LAT-1, go WAIT.
- WAIT: decrement counter; at 0 assert owner's valid, go IDLE.
- if_rdata and d_rdata are combinational pass-through of m_rdata; meaningful only while the matching valid is high.
- IF withdrawal: if if_req drops while IF owns the port, access still completes on memory, if_valid suppressed, FSM returns to IDLE on schedule.
- d_req withdrawal before d_valid is illegal (assertion in bench).
- Both requests in the same IDLE cycle: DATA wins (subject to guard).
- Reset (async, any state): state IDLE, counters 0, all outputs 0 (m_en, m_we, valids, stalls combinationally 0 since valids 0 and stall depends on req; m_addr/m_wdata/m_wstrb 0). In-flight access is dropped; requesters reissue.

## Timing
- Grant decided in IDLE cycle T; m_en high in T+1.
- Store: d_valid at T+1; next grant possible at T+2.
- Read: valid at T+1+MEM_LAT; next grant at T+2+MEM_LAT.
- Back-to-back reads: one access per MEM_LAT+2 cycles.
- m_* outputs registered; stall_* combinational.

## Configuration
- ARB_STARVE_GUARD_EN defined: counter increments on each DATA grant made while if_req is high, clears on any IF grant or when if_req low in IDLE; when counter == STARVE_MAX and both requests pending, IF is granted.
- Undefined: strict DATA priority; IF may starve indefinitely; counter logic absent.

## Test plan
- Single IF read, MEM_LAT=1, if_addr=0x100, m_rdata=0xDEADBEEF at T+2 -> m_en at T+1, if_valid and if_rdata=0xDEADBEEF at T+2, stall_if high T..T+1.
- Store d_addr=0x2004, d_wdata=0x12345678, d_wstrb=0x3 -> m_en=m_we=1, m_wstrb=0x3 at T+1, d_valid at T+1.
- if_req and d_req (load) together at T -> data served first (d_valid T+2), IF granted T+3, if_valid T+5.
- if_req dropped at T+1 of IF read -> m_en still at T+1, no if_valid, FSM IDLE at T+3.
- Guard on, STARVE_MAX=4, d_req held with 5 back-to-back loads, if_req high -> IF granted after 4th load; guard off -> all 5 loads before IF.
- rst_n low during WAIT -> immediately IDLE, all outputs 0, no valid pulse after release.
